cpu0_mem_ctrl: RTL and testbench

- Parametrised, handshaked successor to the CPU0 byte-addressed memory model.
- Sits between the cpu0 core memory port (mar/mdr/m_en/m_rw/m_size) and a byte array.
- Adds configurable wait states, a ready/err completion handshake, range checking, and one memory-mapped output register.
- Access is big-endian; width is selected per access by m_size.

---
 rtl/cpu0_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu0_mem_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu0_mem_ctrl.sv
// Handshaked byte-addressed memory controller for the cpu0 core: wait states,
// ready/err completion, range checking and one memory-mapped output register.
module cpu0_mem_ctrl #(
  parameter int unsigned MEM_SIZE    = 32'h7000,
  parameter logic [31:0] IO_ADDR     = 32'h7000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  FILL        = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        ready,
  output logic        err,
  output logic [31:0] io_data,
  output logic        io_valid
);

  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            io_valid_q, io_valid_d;
  logic [31:0]     dout_q, dout_d;
  logic [31:0]     io_data_q, io_data_d;

  // Bytes are stored XOR FILL so an array that powers up zeroed reads as FILL.
  logic [7:0]      mem [MEM_SIZE];

  logic [32:0]     end_addr;
  logic            is_io;
  logic            acc_err;
  logic            mem_we;
  logic [AW-1:0]   idx [4];
  logic [31:0]     rdata;
  logic [31:0]     wshift;

  // Access decode on the latched request; 33-bit end address never wraps.
  always_comb begin
    end_addr = {1'b0, addr_q} + 33'(size_q) + 33'd1;
    is_io    = (addr_q == IO_ADDR) && (size_q == 2'b11);
    acc_err  = ((addr_q == IO_ADDR) && (size_q != 2'b11)) ||
               (!is_io && (end_addr > 33'(MEM_SIZE)));
    wshift   = data_q << {2'(2'd3 - size_q), 3'b000};
    rdata    = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = addr_q[AW-1:0] + AW'(i);
      if (2'(i) <= size_q) begin
        rdata = {rdata[23:0], mem[idx[i]] ^ FILL};
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rw_d       = rw_q;
    size_d     = size_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    io_valid_d = 1'b0;
    dout_d     = dout_q;
    io_data_d  = io_data_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          addr_d  = abus;
          data_d  = dbus_in;
          rw_d    = rw;
          size_d  = m_size;
          cnt_d   = CW'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          ready_d = 1'b1;
          state_d = DONE;
          if (acc_err) begin
            err_d  = 1'b1;
            dout_d = '0;
          end else if (is_io) begin
            if (rw_q) begin
              dout_d = io_data_q;
            end else begin
              io_data_d  = data_q;
              io_valid_d = 1'b1;
            end
          end else if (rw_q) begin
            dout_d = rdata;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      DONE: state_d = en ? HOLD : IDLE;
      HOLD: if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      io_valid_q <= 1'b0;
      dout_q     <= '0;
      io_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      io_valid_q <= io_valid_d;
      dout_q     <= dout_d;
      io_data_q  <= io_data_d;
    end
  end

  // Array is not reset; writes land big-endian at the completion edge only.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) <= size_q) begin
          mem[idx[i]] <= wshift[31-8*i -: 8] ^ FILL;
        end
      end
    end
  end

  assign dbus_out = dout_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign io_data  = io_data_q;
  assign io_valid = io_valid_q;

endmodule

// File: tb/tb_cpu0_mem_ctrl.sv
// Randomised self-checking bench for cpu0_mem_ctrl against a byte-array model,
// plus a zero-wait-state instance checked by hand.
module tb_cpu0_mem_ctrl;

  localparam int unsigned MEM_SIZE = 32'h7000;
  localparam logic [31:0] IO_ADDR  = 32'h7000;
  localparam int unsigned WS       = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, rw = 1'b0;
  logic [1:0]  m_size = '0;
  logic [31:0] abus = '0, dbus_in = '0;
  logic [31:0] dbus_out, io_data;
  logic        ready, err, io_valid;

  logic        en1 = 1'b0, rw1 = 1'b0;
  logic [1:0]  m_size1 = '0;
  logic [31:0] abus1 = '0, dbus_in1 = '0;
  logic [31:0] dbus_out1, io_data1;
  logic        ready1, err1, io_valid1;

  cpu0_mem_ctrl #(.MEM_SIZE(MEM_SIZE), .IO_ADDR(IO_ADDR), .WAIT_STATES(WS), .FILL(8'hFF)) u_dut (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .m_size(m_size), .abus(abus),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .ready(ready), .err(err),
    .io_data(io_data), .io_valid(io_valid));

  cpu0_mem_ctrl #(.MEM_SIZE(MEM_SIZE), .IO_ADDR(IO_ADDR), .WAIT_STATES(0), .FILL(8'hFF)) u_dut0 (
    .clock(clock), .reset(reset), .en(en1), .rw(rw1), .m_size(m_size1), .abus(abus1),
    .dbus_in(dbus_in1), .dbus_out(dbus_out1), .ready(ready1), .err(err1),
    .io_data(io_data1), .io_valid(io_valid1));

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          vecs = 0;
  int          miss = 0;

  logic [7:0]  mdl_mem [MEM_SIZE];
  logic        pending = 1'b0;
  int unsigned exp_done = 0;
  logic        exp_err = 1'b0, exp_iov = 1'b0;
  logic [31:0] io_cur = '0, io_next = '0, dout_cur = '0, dout_next = '0;
  logic [31:0] got_dout = '0;
  logic        got_err = 1'b0;
  logic        exp_r, done_now;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model's expectations.
  always @(posedge clock) begin
    #1;
    exp_r    = pending && (cyc == exp_done);
    done_now = pending && (cyc >= exp_done);
    chk("ready", 32'(ready), 32'(exp_r));
    if (exp_r) begin
      chk("err", 32'(err), 32'(exp_err));
      chk("io_valid", 32'(io_valid), 32'(exp_iov));
      got_dout = dbus_out;
      got_err  = err;
    end else begin
      chk("err_idle", 32'(err), 32'd0);
      chk("io_valid_idle", 32'(io_valid), 32'd0);
    end
    chk("dbus_out", dbus_out, done_now ? dout_next : dout_cur);
    chk("io_data", io_data, done_now ? io_next : io_cur);
  end

  // Access outcome from the rules: bounds, IO window, big-endian byte order.
  task automatic model(input logic r, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d);
    int unsigned n;
    logic [32:0] e;
    n = 32'(s) + 1;
    e = {1'b0, a} + 33'(n);
    exp_err   = 1'b0;
    exp_iov   = 1'b0;
    dout_next = dout_cur;
    io_next   = io_cur;
    if (a == IO_ADDR) begin
      if (s == 2'b11) begin
        if (r) dout_next = io_cur;
        else begin
          io_next = d;
          exp_iov = 1'b1;
        end
      end else begin
        exp_err   = 1'b1;
        dout_next = '0;
      end
    end else if (e > 33'(MEM_SIZE)) begin
      exp_err   = 1'b1;
      dout_next = '0;
    end else if (r) begin
      dout_next = '0;
      for (int k = 0; k < int'(n); k++) dout_next = (dout_next << 8) | 32'(mdl_mem[a + 32'(k)]);
    end else begin
      for (int k = 0; k < int'(n); k++) mdl_mem[a + 32'(k)] = 8'(d >> (8 * (int'(n) - 1 - k)));
    end
  endtask

  task automatic access(input logic r, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int hold = 0, input bit abort = 1'b0);
    @(negedge clock);
    en = 1'b1; rw = r; m_size = s; abus = a; dbus_in = d;
    if (abort) begin
      @(negedge clock);
      reset = 1'b0; en = 1'b0;
      io_cur = '0; io_next = '0; dout_cur = '0; dout_next = '0;
      @(negedge clock);
      reset = 1'b1;
    end else begin
      model(r, s, a, d);
      exp_done = cyc + 2 + WS;
      pending  = 1'b1;
      while (cyc < exp_done) @(negedge clock);
      repeat (hold) @(negedge clock);
      en = 1'b0;
      pending  = 1'b0;
      dout_cur = dout_next;
      io_cur   = io_next;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_SIZE); i++) mdl_mem[i] = 8'hFF;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    access(1'b0, 2'b11, 32'h100, 32'h12345678);
    access(1'b1, 2'b11, 32'h100, 32'h0);
    chk("lit_rd32", got_dout, 32'h12345678);
    access(1'b1, 2'b00, 32'h101, 32'h0);
    chk("lit_rd8", got_dout, 32'h00000034);
    access(1'b1, 2'b01, 32'h102, 32'h0);
    chk("lit_rd16", got_dout, 32'h00005678);
    access(1'b0, 2'b10, 32'h200, 32'hAABBCCDD);
    access(1'b1, 2'b11, 32'h200, 32'h0);
    chk("lit_rd24_fill", got_dout, 32'hBBCCDDFF);

    access(1'b0, 2'b11, IO_ADDR, 32'd42);
    chk("lit_io_data", io_data, 32'd42);
    access(1'b1, 2'b11, IO_ADDR, 32'h0);
    chk("lit_io_read", got_dout, 32'd42);
    access(1'b0, 2'b00, IO_ADDR, 32'd7);
    chk("lit_io_byte_err", 32'(got_err), 32'd1);
    chk("lit_io_kept", io_data, 32'd42);

    access(1'b1, 2'b11, MEM_SIZE - 2, 32'h0);
    chk("lit_oob_err", 32'(got_err), 32'd1);
    chk("lit_oob_dout", got_dout, 32'd0);
    access(1'b1, 2'b11, MEM_SIZE - 4, 32'h0);
    chk("lit_top_ok", 32'(got_err), 32'd0);
    access(1'b0, 2'b11, 32'hFFFFFFFE, 32'h11223344);
    chk("lit_nowrap_err", 32'(got_err), 32'd1);

    access(1'b1, 2'b11, 32'h100, 32'h0, 10);
    access(1'b1, 2'b11, 32'h100, 32'h0);
    chk("lit_after_hold", got_dout, 32'h12345678);

    access(1'b0, 2'b11, 32'h300, 32'hDEADBEEF, 0, 1'b1);
    chk("lit_rst_io", io_data, 32'd0);
    access(1'b1, 2'b11, 32'h300, 32'h0);
    chk("lit_abort_nowrite", got_dout, 32'hFFFFFFFF);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = 32'h100 + 32'($urandom_range(0, 63));
        1: a = MEM_SIZE - 4 + 32'($urandom_range(0, 5));
        2: a = IO_ADDR;
        default: a = $urandom;
      endcase
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
             $urandom_range(0, 2));
    end

    // Zero-wait-state instance: ready on the first edge after accept.
    @(negedge clock);
    en1 = 1'b1; rw1 = 1'b0; m_size1 = 2'b11; abus1 = 32'h10; dbus_in1 = 32'hCAFEF00D;
    @(posedge clock); #1;
    chk("ws0_wr_accept", 32'(ready1), 32'd0);
    @(posedge clock); #1;
    chk("ws0_wr_ready", 32'(ready1), 32'd1);
    chk("ws0_wr_err", 32'(err1), 32'd0);
    @(negedge clock);
    en1 = 1'b0;
    @(negedge clock);
    en1 = 1'b1; rw1 = 1'b1;
    @(posedge clock); #1;
    chk("ws0_rd_accept", 32'(ready1), 32'd0);
    @(posedge clock); #1;
    chk("ws0_rd_ready", 32'(ready1), 32'd1);
    chk("ws0_rd_data", dbus_out1, 32'hCAFEF00D);
    @(negedge clock);
    en1 = 1'b0;
    @(posedge clock); #1;
    chk("ws0_ready_drop", 32'(ready1), 32'd0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
